// File: rtl/alu16_sequencer_if.sv
// alu16_sequencer_if: nibble-wide bus between the sequencer and an external 4-bit ALU slice
interface alu16_sequencer_if;
    logic [3:0] alu_A;
    logic [3:0] alu_B;
    logic [2:0] alu_S;
    logic       alu_C_in;
    logic [3:0] alu_F;
    logic       alu_C_1;
    modport master (output alu_A, alu_B, alu_S, alu_C_in, input alu_F, alu_C_1);
    modport slave  (input alu_A, alu_B, alu_S, alu_C_in, output alu_F, alu_C_1);
endinterface

// File: rtl/alu16_sequencer.sv
// alu16_sequencer: runs a wide ALU operation one nibble per cycle through an external 4-bit slice
module alu16_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic [2:0]             S,
    alu16_sequencer_if.master      alu,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   F,
    output logic                   C_out,
    output logic                   Z
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state, state_nxt;
    logic [W-1:0]  a_q, b_q;
    logic [2:0]    s_q;
    logic [IW-1:0] idx;
    logic          carry;
    logic          last;
    assign last = idx == IW'(NIBBLES - 1);
    assign Z    = F == '0;
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    // next state, status flags and slice drive (slice bus idles at zero)
    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        done         = 1'b0;
        alu.alu_A    = '0;
        alu.alu_B    = '0;
        alu.alu_S    = '0;
        alu.alu_C_in = 1'b0;
        case (state)
            IDLE: state_nxt = start ? RUN : IDLE;
            RUN: begin
                busy         = 1'b1;
                alu.alu_A    = a_q[4*idx +: 4];
                alu.alu_B    = b_q[4*idx +: 4];
                alu.alu_S    = s_q;
                alu.alu_C_in = carry;
                state_nxt    = last ? DONE : RUN;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // operand capture on accept, nibble write-back and carry chaining while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            F     <= '0;
            C_out <= 1'b0;
        end else if (state == IDLE && start) begin
            a_q   <= A;
            b_q   <= B;
            s_q   <= S;
            idx   <= '0;
            carry <= S == 3'b001 || S == 3'b010;
        end else if (state == RUN) begin
            F[4*idx +: 4] <= alu.alu_F;
            carry         <= alu.alu_C_1;
            C_out         <= alu.alu_C_1;
            idx           <= idx + 1'b1;
        end
    end
endmodule

// File: doc/alu16_sequencer.md
ALU16_SEQUENCER -- requirements
Module: alu16_sequencer

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, meaning the number of 4-bit slices per operand; the operand width is 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port A, input, 16 bits: operand A.
REQ-006 The block SHALL have port B, input, 16 bits: operand B.
REQ-007 The block SHALL have port S, input, 3 bits: operation code, with the same encoding as the 4-bit ALU slice.
REQ-008 The block SHALL have port alu_A, output, 4 bits: A nibble driven to the external slice.
REQ-009 The block SHALL have port alu_B, output, 4 bits: B nibble driven to the external slice.
REQ-010 The block SHALL have port alu_S, output, 3 bits: opcode driven to the external slice.
REQ-011 The block SHALL have port alu_C_in, output, 1 bit: carry into the slice.
REQ-012 The block SHALL have port alu_F, input, 4 bits: slice result.
REQ-013 The block SHALL have port alu_C_1, input, 1 bit: slice carry out.
REQ-014 The block SHALL have port busy, output, 1 bit: high while the operation is in progress.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 The block SHALL have port F, output, 16 bits: assembled result.
REQ-017 The block SHALL have port C_out, output, 1 bit: final carry.
REQ-018 The block SHALL have port Z, output, 1 bit: high when F is zero.

Function
REQ-019 The FSM SHALL have three states, IDLE, RUN and DONE; IDLE->RUN on start; RUN->DONE after the last nibble; DONE->IDLE unconditionally.
REQ-020 In IDLE with start=1, the block SHALL latch A, B and S, clear nibble index idx to 0, and load the carry register.
- Carry register SHALL load 1 for S=001 or S=010 (subtract).
- Carry register SHALL load 0 for all other S.
REQ-021 start SHALL be ignored in RUN and DONE; latched operands SHALL NOT change until the next accepted start.
REQ-022 In RUN, the block SHALL drive the following combinationally from registers:
- alu_A = latched A[4*idx+3 : 4*idx].
- alu_B = latched B[4*idx+3 : 4*idx].
- alu_S = latched S.
- alu_C_in = carry register.
REQ-023 At each RUN clock edge, the block SHALL write alu_F into result nibble idx, load alu_C_1 into the carry register, and increment idx.
REQ-024 RUN SHALL last exactly NIBBLES cycles; after the edge that writes nibble NIBBLES-1, the state SHALL be DONE.
REQ-025 busy SHALL be 1 in RUN only.
REQ-026 done SHALL be 1 in DONE only, for exactly one cycle.
REQ-027 With start accepted at edge k, done SHALL be high in the cycle following edge k+NIBBLES.
REQ-028 C_out SHALL equal the carry register after the final nibble; Z SHALL equal (F==0).
- F, C_out and Z SHALL update only on RUN edges.
- F, C_out and Z SHALL hold from DONE until the next accepted start.
REQ-029 Outside RUN, alu_A, alu_B, alu_S and alu_C_in SHALL be 0.
REQ-030 Carry SHALL chain for every opcode, including the logic ops; the slice defines its meaning.
REQ-031 start held high continuously SHALL launch a new operation every NIBBLES+2 cycles (IDLE, RUN x NIBBLES, DONE).
REQ-032 Operands changing on A, B or S during RUN SHALL have no effect on the result in progress.

Reset
REQ-033 Asserting rst at any time, including mid-RUN, SHALL immediately do all of the following:
- Force state to IDLE.
- Clear idx, the carry register and the latched operands.
- Clear F and C_out to 0 and set Z to 1.
- Clear busy and done to 0.
- Drive alu_A, alu_B, alu_S and alu_C_in to 0.
REQ-034 After rst deasserts, the first start SHALL be accepted on the first rising edge at which start=1.

Verification (bench connects a behavioural 4-bit two's-complement slice)
REQ-035 Add: A=0x1234, B=0x0FFF, S=011, start pulse -> busy for 4 cycles, then done; F=0x2233, C_out=0, Z=0.
REQ-036 Subtract: A=0x1234, B=0x0FFF, S=010 -> alu_C_in=1 on nibble 0; F=0x0235, C_out=1 (no borrow).
REQ-037 Zero/wrap: A=0xFFFF, B=0x0001, S=011 -> F=0x0000, C_out=1, Z=1; the carry ripples through all 4 nibbles.
REQ-038 Busy ignore: start again during RUN with a different A -> the result reflects only the first operands; no extra done pulse.
REQ-039 Reset mid-op: rst asserted in RUN cycle 2 -> busy=0, F=0, Z=1 immediately; the next start yields a correct fresh result.
REQ-040 Back-to-back: start held high for 3 operations -> done pulses at a spacing of 6 cycles; each F matches its operands.
